// File: rtl/rv32_mc_control.sv
`default_nettype none
// rv32_mc_control: main control FSM for the RV32I multicycle datapath.
// Sequences fetch/decode/execute/memory/writeback and traps on illegal opcodes or memory timeout.
module rv32_mc_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        JALR2    = 4'd12,
        LUI      = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam int         CNT_W         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    state_t             state, state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic [1:0]         cause, cause_next;
    logic               waiting, timeout, take, br_legal;

    assign waiting = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem_ready;
    // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting &&
                     ((32'(wait_cnt) + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            cause    <= 2'b00;
        end else begin
            state    <= state_next;
            cause    <= cause_next;
            wait_cnt <= (waiting && !timeout) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        take     = 1'b0;
        br_legal = 1'b1;
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = !zero;
            3'b100:  take = lt;
            3'b101:  take = !lt;
            3'b110:  take = ltu;
            3'b111:  take = !ltu;
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    7'b0000011, 7'b0100011: state_next = MEMADR;
                    7'b0110011:             state_next = EXECR;
                    7'b0010011:             state_next = EXECI;
                    7'b1100011:             state_next = BRANCH;
                    7'b1101111:             state_next = JAL;
                    7'b1100111:             state_next = JALR;
                    7'b0110111:             state_next = LUI;
                    7'b0010111:             state_next = ALUWB;
                    default: begin
                        state_next = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                if (br_legal) begin
                    pc_write   = take;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = JALR2;
            end
            JALR2: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        trap_cause = cause;
        state_dbg  = state;

        // Outputs are forced quiet for the whole time reset is held.
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            alu_op     = 2'b00;
            instr_done = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'b00;
            state_dbg  = 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mc_control.sv
`default_nettype none
// tb_rv32_mc_control: directed cycle-by-cycle check of the multicycle control FSM.
module tb_rv32_mc_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [1:0] op;
        logic       done;
        logic       trap;
        logic [1:0] cause;
        logic [3:0] st;
    } ctl_t;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,  S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8,  S_BRANCH = 4'd9, S_JAL = 4'd10,   S_JALR = 4'd11;
    localparam logic [3:0] S_JALR2 = 4'd12, S_LUI = 4'd13,   S_TRAP = 4'd14;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       instr_done, trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;
    ctl_t       obs;

    int   checks = 0;
    int   errors = 0;
    ctl_t sb[$];

    rv32_mc_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .instr_done(instr_done), .trap(trap),
        .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_op,
                  instr_done, trap, trap_cause, state_dbg};

    // Expected outputs: Moore fields from the state table, gated strobes supplied by the caller.
    function automatic ctl_t ev(input logic [3:0] s, input logic pcw, input logic irw,
                                input logic done, input logic [1:0] cause);
        ctl_t e = '0;
        e.st = s; e.pc_write = pcw; e.ir_write = irw; e.done = done; e.cause = cause;
        case (s)
            S_FETCH:    begin e.mem_req = 1'b1; e.b = 2'b10; e.rs = 2'b10; end
            S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; end
            S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
            S_MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
            S_MEMWB:    begin e.rs = 2'b01; e.reg_write = 1'b1; end
            S_MEMWRITE: begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
            S_EXECR:    begin e.a = 2'b10; e.b = 2'b00; e.op = 2'b10; end
            S_EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
            S_ALUWB:    begin e.rs = 2'b00; e.reg_write = 1'b1; end
            S_BRANCH:   begin e.a = 2'b10; e.b = 2'b00; e.op = 2'b01; end
            S_JAL:      begin e.a = 2'b01; e.b = 2'b10; end
            S_JALR:     begin e.a = 2'b10; e.b = 2'b01; end
            S_JALR2:    begin e.a = 2'b01; e.b = 2'b10; end
            S_LUI:      begin e.rs = 2'b11; e.reg_write = 1'b1; end
            S_TRAP:     e.trap = 1'b1;
            default:    ;
        endcase
        return e;
    endfunction

    task automatic sample(input string tag);
        ctl_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic now(input string tag, input ctl_t e);
        sb.push_back(e);
        sample(tag);
    endtask

    task automatic step(input string tag, input logic [3:0] s, input logic pcw,
                        input logic irw, input logic done, input logic [1:0] cause);
        sb.push_back(ev(s, pcw, irw, done, cause));
        @(negedge clk);
        sample(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input string tag);
        mem_ready = 1'b1;
        step(tag, S_FETCH, 1'b1, 1'b1, 1'b0, 2'b00);
        mem_ready = 1'b0;
        step({tag, "_dec"}, S_DECODE, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Called at posedge+1: pulse reset, check outputs are quiet, release before the next negedge.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1 now(tag, '0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; opcode = 7'h00; funct3 = 3'b000;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        now("reset_held", '0);
        @(posedge clk); #1;
        now("reset_held2", '0);
        reset = 1'b0;

        // ADD
        opcode = 7'b0110011;
        fetch_ok("add");
        step("add_execr", S_EXECR, 1'b0, 1'b0, 1'b0, 2'b00);
        step("add_aluwb", S_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00);

        // Load with three wait cycles in MEMREAD, ready on the 4th (timeout boundary)
        opcode = 7'b0000011; funct3 = 3'b010;
        fetch_ok("lw");
        step("lw_memadr", S_MEMADR, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) step("lw_memread_wait", S_MEMREAD, 1'b0, 1'b0, 1'b0, 2'b00);
        mem_ready = 1'b1;
        step("lw_memread_ready", S_MEMREAD, 1'b0, 1'b0, 1'b0, 2'b00);
        mem_ready = 1'b0;
        step("lw_memwb", S_MEMWB, 1'b0, 1'b0, 1'b1, 2'b00);

        // BNE not taken, BNE taken, BLTU taken, BLT not taken
        opcode = 7'b1100011; funct3 = 3'b001; zero = 1'b1;
        fetch_ok("bne_nt");
        step("bne_nt_branch", S_BRANCH, 1'b0, 1'b0, 1'b1, 2'b00);
        zero = 1'b0;
        fetch_ok("bne_t");
        step("bne_t_branch", S_BRANCH, 1'b1, 1'b0, 1'b1, 2'b00);
        funct3 = 3'b110; ltu = 1'b1;
        fetch_ok("bltu");
        step("bltu_branch", S_BRANCH, 1'b1, 1'b0, 1'b1, 2'b00);
        funct3 = 3'b100; lt = 1'b0; ltu = 1'b1;
        fetch_ok("blt_nt");
        step("blt_nt_branch", S_BRANCH, 1'b0, 1'b0, 1'b1, 2'b00);

        // ADDI, JAL, JALR, LUI, AUIPC
        opcode = 7'b0010011;
        fetch_ok("addi");
        step("addi_execi", S_EXECI, 1'b0, 1'b0, 1'b0, 2'b00);
        step("addi_aluwb", S_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00);
        opcode = 7'b1101111;
        fetch_ok("jal");
        step("jal_jal", S_JAL, 1'b1, 1'b0, 1'b0, 2'b00);
        step("jal_aluwb", S_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00);
        opcode = 7'b1100111;
        fetch_ok("jalr");
        step("jalr_jalr", S_JALR, 1'b0, 1'b0, 1'b0, 2'b00);
        step("jalr_jalr2", S_JALR2, 1'b1, 1'b0, 1'b0, 2'b00);
        step("jalr_aluwb", S_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00);
        opcode = 7'b0110111;
        fetch_ok("lui");
        step("lui_lui", S_LUI, 1'b0, 1'b0, 1'b1, 2'b00);
        opcode = 7'b0010111;
        fetch_ok("auipc");
        step("auipc_aluwb", S_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00);

        // Store with two wait cycles
        opcode = 7'b0100011;
        fetch_ok("sw");
        step("sw_memadr", S_MEMADR, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 2; i++) step("sw_wait", S_MEMWRITE, 1'b0, 1'b0, 1'b0, 2'b00);
        mem_ready = 1'b1;
        step("sw_ready", S_MEMWRITE, 1'b0, 1'b0, 1'b1, 2'b00);

        // Reset pulsed mid-MEMWRITE
        fetch_ok("sw_rst");
        step("sw_rst_memadr", S_MEMADR, 1'b0, 1'b0, 1'b0, 2'b00);
        step("sw_rst_wait", S_MEMWRITE, 1'b0, 1'b0, 1'b0, 2'b00);
        pulse_reset("sw_rst_pulse");
        step("sw_rst_fetch", S_FETCH, 1'b0, 1'b0, 1'b0, 2'b00);

        // Illegal opcode: sticky trap for 20 cycles regardless of mem_ready
        opcode = 7'b0000000;
        fetch_ok("illegal");
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("illegal_trap", S_TRAP, 1'b0, 1'b0, 1'b0, 2'b01);
        end
        pulse_reset("illegal_reset");

        // Fetch timeout after four wait cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("tmo_fetch_wait", S_FETCH, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) step("tmo_trap", S_TRAP, 1'b0, 1'b0, 1'b0, 2'b10);
        pulse_reset("tmo_reset");

        // Reserved branch funct3 traps without writing the PC
        opcode = 7'b1100011; funct3 = 3'b010; zero = 1'b1;
        fetch_ok("brbad");
        step("brbad_branch", S_BRANCH, 1'b0, 1'b0, 1'b0, 2'b00);
        step("brbad_trap", S_TRAP, 1'b0, 1'b0, 1'b0, 2'b01);
        pulse_reset("brbad_reset");
        step("final_fetch", S_FETCH, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_mc_control.md
Name: rv32_mc_control

Overview:
- Main control FSM for the RV32I multicycle datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit selects of the shared 4:1 datapath muxes (ALU A, ALU B, result) plus the register, memory and PC enables.
- Handshakes with a variable-latency memory and has a memory-timeout trap.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ready in one memory state. 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  7  instruction register [6:0]
- funct3  input  3  instruction register [14:12]
- zero  input  1  ALU result == 0
- lt  input  1  signed rs1 < rs2
- ltu  input  1  unsigned rs1 < rs2
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- mem_write  output  1  store strobe
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  load IR and old_pc
- pc_write  output  1  PC load enable
- reg_write  output  1  register file write enable
- alu_src_a  output  2  00 PC, 01 old_pc, 10 rs1 reg, 11 zero
- alu_src_b  output  2  00 rs2 reg, 01 imm, 10 const 4, 11 reserved
- result_src  output  2  00 ALUOut, 01 mem data reg, 10 ALU result, 11 imm
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded
- instr_done  output  1  one-cycle pulse when an instruction retires
- trap  output  1  sticky fault flag
- trap_cause  output  2  01 illegal instruction, 10 memory timeout
- state_dbg  output  4  current state encoding

Behaviour:
- Reset (asynchronous, active-high) forces state FETCH, timeout counter 0, trap 0 and trap_cause 00. All outputs read 0 while reset is high.
- After reset, outputs are Moore-decoded from the state. The exceptions are pc_write, ir_write, reg_write on memory states, and instr_done, which are gated combinationally as stated below.
- Default for every output not listed in a state: 0.

States and transitions:
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write are asserted only in the cycle mem_ready=1, and the FSM then goes to DECODE. Otherwise it holds in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (ALUOut <= old_pc+imm). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 (AUIPC) -> ALUWB
  - anything else -> TRAP with cause 01
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, both held until mem_ready. On mem_ready: instr_done=1 -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, instr_done=1 -> FETCH.
  - pc_write = take, where funct3 selects: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010 or 011 -> TRAP with cause 01, no PC write.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (links old_pc+4).
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00 (ALUOut <= rs1+imm) -> JALR2. The datapath clears the LSB of the target.
- JALR2: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB.
- LUI: result_src=11, reg_write=1, instr_done=1 -> FETCH.
- TRAP: all enables 0, trap=1. Exit only by reset.

Timeout:
- The counter increments each cycle spent in FETCH, MEMREAD or MEMWRITE while mem_ready=0.
- It clears on mem_ready or on leaving those states.
- When the count reaches TIMEOUT_CYCLES (nonzero), the next state is TRAP with cause 10. mem_req and mem_write drop the cycle after.

Latency:
- R/I/AUIPC/JAL/branch/LUI: 3–4 cycles plus fetch wait. Load: 5 + waits. Store: 4 + waits. JALR: 5.

Simultaneous events:
- mem_ready takes priority over timeout in the same cycle.
- Reset mid-instruction discards it: no partial writes after reset deasserts.

Test Plan:
- Reset mid-MEMWRITE, with mem_ready=0 and reset pulsed -> mem_write=0 immediately, state_dbg=FETCH, trap=0.
- ADD (opcode 0110011), mem_ready=1 in FETCH -> FETCH, DECODE, EXECR, ALUWB. reg_write=1 only in cycle 4. instr_done pulses once. alu_op=10 in EXECR.
- Load with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles. reg_write with result_src=01 one cycle after mem_ready. Total 8 cycles.
- BNE (funct3 001): zero=1 -> no pc_write; zero=0 -> pc_write=1 in BRANCH with alu_op=01. BLTU with ltu=1 -> pc_write=1.
- Opcode 0000000 -> TRAP after DECODE, trap_cause=01, all enables 0 for 20 cycles, leaves only on reset.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> TRAP with trap_cause=10 after 4 wait cycles. ir_write is never asserted.
